// File: rtl/cajero_pkg.sv
// Shared types and constants for the parametrised ATM controller.
//   estado_t      : controller state encoding
//   TIPO_DEPOSITO : TIPO_TRANS value selecting a deposit
//   TIPO_RETIRO   : TIPO_TRANS value selecting a withdrawal
package cajero_pkg;

    typedef enum logic [2:0] {
        ESPERA_TARJETA = 3'd0,
        RECIBE_PIN     = 3'd1,
        VERIFICA_PIN   = 3'd2,
        ESPERA_MONTO   = 3'd3,
        FIN            = 3'd4,
        BLOQUEADO      = 3'd5
    } estado_t;

    localparam logic TIPO_DEPOSITO = 1'b0;
    localparam logic TIPO_RETIRO   = 1'b1;

endpackage

// File: rtl/cajero_param_if.sv
// Card/PIN/amount handshake and result bus of the ATM controller.
// master : stimulus side (drives card, strobes, PIN, amounts; reads results)
// slave  : controller side
// LIMITE_DIARIO_EN adds the LIMITE_EXCEDIDO result pulse.
interface cajero_param_if #(
    parameter int unsigned N_DIGITOS = 4,
    parameter int unsigned MONTO_W   = 32,
    parameter int unsigned BALANCE_W = 64
);
    localparam int unsigned PIN_W = 4 * N_DIGITOS;

    logic                 TARJETA_RECIBIDA;
    logic                 TIPO_TRANS;
    logic                 DIGITO_STB;
    logic [3:0]           DIGITO;
    logic [PIN_W-1:0]     PIN;
    logic                 MONTO_STB;
    logic [MONTO_W-1:0]   MONTO;
    logic [BALANCE_W-1:0] BALANCE_INICIAL;
    logic [BALANCE_W-1:0] BALANCE;
    logic                 BALANCE_ACTUALIZADO;
    logic                 ENTREGAR_DINERO;
    logic                 PIN_INCORRECTO;
    logic                 ADVERTENCIA;
    logic                 BLOQUEO;
    logic                 FONDOS_INSUFICIENTES;

`ifdef LIMITE_DIARIO_EN
    logic                 LIMITE_EXCEDIDO;

    modport master (
        output TARJETA_RECIBIDA, TIPO_TRANS, DIGITO_STB, DIGITO, PIN,
               MONTO_STB, MONTO, BALANCE_INICIAL,
        input  BALANCE, BALANCE_ACTUALIZADO, ENTREGAR_DINERO, PIN_INCORRECTO,
               ADVERTENCIA, BLOQUEO, FONDOS_INSUFICIENTES, LIMITE_EXCEDIDO
    );
    modport slave (
        input  TARJETA_RECIBIDA, TIPO_TRANS, DIGITO_STB, DIGITO, PIN,
               MONTO_STB, MONTO, BALANCE_INICIAL,
        output BALANCE, BALANCE_ACTUALIZADO, ENTREGAR_DINERO, PIN_INCORRECTO,
               ADVERTENCIA, BLOQUEO, FONDOS_INSUFICIENTES, LIMITE_EXCEDIDO
    );
`else
    modport master (
        output TARJETA_RECIBIDA, TIPO_TRANS, DIGITO_STB, DIGITO, PIN,
               MONTO_STB, MONTO, BALANCE_INICIAL,
        input  BALANCE, BALANCE_ACTUALIZADO, ENTREGAR_DINERO, PIN_INCORRECTO,
               ADVERTENCIA, BLOQUEO, FONDOS_INSUFICIENTES
    );
    modport slave (
        input  TARJETA_RECIBIDA, TIPO_TRANS, DIGITO_STB, DIGITO, PIN,
               MONTO_STB, MONTO, BALANCE_INICIAL,
        output BALANCE, BALANCE_ACTUALIZADO, ENTREGAR_DINERO, PIN_INCORRECTO,
               ADVERTENCIA, BLOQUEO, FONDOS_INSUFICIENTES
    );
`endif

endinterface

// File: rtl/cajero_pin_captura.sv
// PIN digit capture: shift register filled from the LS side plus digit counter.
//   clk, rst    : clock, async active-low reset
//   clr         : clear digits and count (priority over DIGITO_STB)
//   DIGITO_STB  : qualified digit strobe (already gated by the controller)
//   DIGITO      : BCD digit
//   digitos     : captured digits, first digit ends up in the MS nibble
//   completo    : combinational, high on the strobe delivering the last digit
module cajero_pin_captura #(
    parameter int unsigned N_DIGITOS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   DIGITO_STB,
    input  logic [3:0]             DIGITO,
    output logic [4*N_DIGITOS-1:0] digitos,
    output logic                   completo
);
    localparam int unsigned PIN_W = 4 * N_DIGITOS;
    localparam int unsigned CNT_W = $clog2(N_DIGITOS + 1);

    logic [CNT_W-1:0] cuenta;

    // Lets the controller move to verification on the same edge the last digit lands
    assign completo = DIGITO_STB && (cuenta == CNT_W'(N_DIGITOS - 1));

    // Shift register and digit counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digitos <= '0;
            cuenta  <= '0;
        end else if (clr) begin
            digitos <= '0;
            cuenta  <= '0;
        end else if (DIGITO_STB) begin
            digitos <= PIN_W'({digitos, DIGITO});
            cuenta  <= cuenta + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cajero_param.sv
// Parametrised ATM transaction controller.
//   clk, rst : clock, async active-low reset
//   bus      : cajero_param_if.slave (card, PIN digits, amount in; balance and
//              result flags out, all registered)
// Build macro LIMITE_DIARIO_EN enables the cumulative withdrawal limit.
module cajero_param
    import cajero_pkg::*;
#(
    parameter int unsigned N_DIGITOS     = 4,
    parameter int unsigned MONTO_W       = 32,
    parameter int unsigned BALANCE_W     = 64,
    parameter int unsigned MAX_INTENTOS  = 3,
    parameter int unsigned LIMITE_RETIRO = 500000
) (
    input  logic           clk,
    input  logic           rst,
    cajero_param_if.slave  bus
);
    localparam int unsigned PIN_W = 4 * N_DIGITOS;
    localparam int unsigned CMP_W = BALANCE_W + 1;
    localparam int unsigned INT_W = $clog2(MAX_INTENTOS + 1);
    localparam int unsigned ACC_W = MONTO_W + 1;
    localparam int unsigned LIM_W = MONTO_W + 2;

    estado_t              estado_q, estado_d;
    logic [BALANCE_W-1:0] balance_q, balance_d;
    logic                 tipo_q, tipo_d;
    logic [INT_W-1:0]     intentos_q, intentos_d;
    logic                 adv_q, adv_d;
    logic                 bloq_q, bloq_d;
    logic                 act_q, act_d;
    logic                 entregar_q, entregar_d;
    logic                 pin_inc_q, pin_inc_d;
    logic                 fondos_q, fondos_d;
    logic                 pend_q, pend_d;
    logic [MONTO_W-1:0]   monto_q, monto_d;

    logic [CMP_W-1:0]     suma;
    logic [INT_W-1:0]     intentos_inc;
    logic                 sin_fondos;
    logic                 clr_c;
    logic                 stb_c;
    logic [PIN_W-1:0]     digitos;
    logic                 completo;

`ifdef LIMITE_DIARIO_EN
    logic [ACC_W-1:0]     acum_q, acum_d;
    logic                 limite_q, limite_d;
    logic [LIM_W-1:0]     acum_suma;
    logic                 excede;
`else
    logic                 unused_limite;
    assign unused_limite = ^{32'(LIMITE_RETIRO), 32'(ACC_W), 32'(LIM_W)};
`endif

    // Digits are only accepted while collecting a PIN with the card present
    assign stb_c = (estado_q == RECIBE_PIN) && bus.TARJETA_RECIBIDA && bus.DIGITO_STB;

    cajero_pin_captura #(
        .N_DIGITOS (N_DIGITOS)
    ) u_pin (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr_c),
        .DIGITO_STB (stb_c),
        .DIGITO     (bus.DIGITO),
        .digitos    (digitos),
        .completo   (completo)
    );

    // Next-state and registered-output logic
    always_comb begin
        estado_d     = estado_q;
        balance_d    = balance_q;
        tipo_d       = tipo_q;
        intentos_d   = intentos_q;
        adv_d        = adv_q;
        bloq_d       = bloq_q;
        act_d        = 1'b0;
        entregar_d   = 1'b0;
        pin_inc_d    = 1'b0;
        fondos_d     = 1'b0;
        pend_d       = pend_q;
        monto_d      = monto_q;
        clr_c        = 1'b0;
        suma         = CMP_W'(balance_q) + CMP_W'(monto_q);
        sin_fondos   = CMP_W'(monto_q) > CMP_W'(balance_q);
        intentos_inc = intentos_q + INT_W'(1);
`ifdef LIMITE_DIARIO_EN
        acum_d       = acum_q;
        limite_d     = 1'b0;
        acum_suma    = LIM_W'(acum_q) + LIM_W'(monto_q);
        excede       = acum_suma > LIM_W'(LIMITE_RETIRO);
`endif

        case (estado_q)
            ESPERA_TARJETA: begin
                if (bus.TARJETA_RECIBIDA) begin
                    balance_d = bus.BALANCE_INICIAL;
                    tipo_d    = bus.TIPO_TRANS;
                    clr_c     = 1'b1;
                    estado_d  = RECIBE_PIN;
                end
            end
            RECIBE_PIN: begin
                if (!bus.TARJETA_RECIBIDA) begin
                    estado_d = ESPERA_TARJETA;
                end else if (completo) begin
                    estado_d = VERIFICA_PIN;
                end
            end
            VERIFICA_PIN: begin
                if (!bus.TARJETA_RECIBIDA) begin
                    estado_d = ESPERA_TARJETA;
                end else if (digitos == bus.PIN) begin
                    intentos_d = '0;
                    adv_d      = 1'b0;
                    estado_d   = ESPERA_MONTO;
                end else begin
                    pin_inc_d  = 1'b1;
                    intentos_d = intentos_inc;
                    if (intentos_inc == INT_W'(MAX_INTENTOS)) begin
                        bloq_d   = 1'b1;
                        estado_d = BLOQUEADO;
                    end else begin
                        if (intentos_inc == INT_W'(MAX_INTENTOS - 1)) begin
                            adv_d = 1'b1;
                        end
                        clr_c    = 1'b1;
                        estado_d = RECIBE_PIN;
                    end
                end
            end
            ESPERA_MONTO: begin
                // Amount is captured on the strobe edge and applied one cycle later;
                // an already accepted amount completes even if the card goes away
                if (pend_q) begin
                    pend_d   = 1'b0;
                    estado_d = FIN;
                    if (tipo_q == TIPO_DEPOSITO) begin
                        balance_d = suma[BALANCE_W] ? '1 : suma[BALANCE_W-1:0];
                        act_d     = 1'b1;
                    end else if (sin_fondos) begin
                        fondos_d = 1'b1;
`ifdef LIMITE_DIARIO_EN
                    end else if (excede) begin
                        limite_d = 1'b1;
`endif
                    end else begin
                        balance_d  = balance_q - BALANCE_W'(monto_q);
                        act_d      = 1'b1;
                        entregar_d = 1'b1;
`ifdef LIMITE_DIARIO_EN
                        acum_d     = ACC_W'(acum_suma);
`endif
                    end
                end else if (!bus.TARJETA_RECIBIDA) begin
                    estado_d = ESPERA_TARJETA;
                end else if (bus.MONTO_STB) begin
                    pend_d  = 1'b1;
                    monto_d = bus.MONTO;
                end
            end
            FIN: begin
                if (!bus.TARJETA_RECIBIDA) begin
                    estado_d = ESPERA_TARJETA;
                end
            end
            BLOQUEADO: begin
                estado_d = BLOQUEADO;
            end
            default: begin
                estado_d = ESPERA_TARJETA;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q   <= ESPERA_TARJETA;
            balance_q  <= '0;
            tipo_q     <= 1'b0;
            intentos_q <= '0;
            adv_q      <= 1'b0;
            bloq_q     <= 1'b0;
            act_q      <= 1'b0;
            entregar_q <= 1'b0;
            pin_inc_q  <= 1'b0;
            fondos_q   <= 1'b0;
            pend_q     <= 1'b0;
            monto_q    <= '0;
`ifdef LIMITE_DIARIO_EN
            acum_q     <= '0;
            limite_q   <= 1'b0;
`endif
        end else begin
            estado_q   <= estado_d;
            balance_q  <= balance_d;
            tipo_q     <= tipo_d;
            intentos_q <= intentos_d;
            adv_q      <= adv_d;
            bloq_q     <= bloq_d;
            act_q      <= act_d;
            entregar_q <= entregar_d;
            pin_inc_q  <= pin_inc_d;
            fondos_q   <= fondos_d;
            pend_q     <= pend_d;
            monto_q    <= monto_d;
`ifdef LIMITE_DIARIO_EN
            acum_q     <= acum_d;
            limite_q   <= limite_d;
`endif
        end
    end

    assign bus.BALANCE              = balance_q;
    assign bus.BALANCE_ACTUALIZADO  = act_q;
    assign bus.ENTREGAR_DINERO      = entregar_q;
    assign bus.PIN_INCORRECTO       = pin_inc_q;
    assign bus.ADVERTENCIA          = adv_q;
    assign bus.BLOQUEO              = bloq_q;
    assign bus.FONDOS_INSUFICIENTES = fondos_q;
`ifdef LIMITE_DIARIO_EN
    assign bus.LIMITE_EXCEDIDO      = limite_q;
`endif

endmodule

// File: tb/tb_cajero_param.sv
// Self-checking bench for cajero_param (defaults: 4 digits, 32/64-bit, 3 attempts).
module tb_cajero_param;
    localparam int unsigned LIM    = 500;
    localparam int          MAXI   = 3;
    localparam logic [15:0] PIN_OK = 16'h1234;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    // Reference model state
    logic [63:0]     m_bal;
    int              m_intentos;
    logic            m_adv;
    logic            m_bloq;
    longint unsigned m_acum;

    cajero_param_if #(.N_DIGITOS(4), .MONTO_W(32), .BALANCE_W(64)) bus ();

    cajero_param #(
        .N_DIGITOS     (4),
        .MONTO_W       (32),
        .BALANCE_W     (64),
        .MAX_INTENTOS  (MAXI),
        .LIMITE_RETIRO (LIM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- model ----------------
    function automatic void model_pin_fail();
        m_intentos++;
        if (m_intentos >= MAXI) m_bloq = 1'b1;
        else if (m_intentos == MAXI - 1) m_adv = 1'b1;
    endfunction

    function automatic void model_pin_ok();
        m_intentos = 0;
        m_adv      = 1'b0;
    endfunction

    function automatic void model_tx(input logic tipo, input logic [31:0] m,
                                     output logic act, output logic ent,
                                     output logic fnd, output logic lim);
        logic [63:0] margen;
        act = 0; ent = 0; fnd = 0; lim = 0;
        if (tipo == 1'b0) begin
            margen = 64'hFFFF_FFFF_FFFF_FFFF - m_bal;
            if (64'(m) > margen) m_bal = 64'hFFFF_FFFF_FFFF_FFFF;
            else m_bal = m_bal + 64'(m);
            act = 1;
        end else if (64'(m) > m_bal) begin
            fnd = 1;
`ifdef LIMITE_DIARIO_EN
        end else if (m_acum + longint'(m) > longint'(LIM)) begin
            lim = 1;
`endif
        end else begin
            m_bal  = m_bal - 64'(m);
            m_acum = m_acum + longint'(m);
            act = 1;
            ent = 1;
        end
    endfunction

    function automatic logic lim_out();
`ifdef LIMITE_DIARIO_EN
        return bus.LIMITE_EXCEDIDO;
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- drivers ----------------
    task automatic do_reset();
        rst = 1'b0;
        bus.TARJETA_RECIBIDA = 0; bus.TIPO_TRANS = 0; bus.DIGITO_STB = 0;
        bus.DIGITO = 0; bus.MONTO_STB = 0; bus.MONTO = 0;
        bus.BALANCE_INICIAL = 0; bus.PIN = PIN_OK;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_bal = 0; m_intentos = 0; m_adv = 0; m_bloq = 0; m_acum = 0;
    endtask

    task automatic insert_card(input logic tipo, input logic [63:0] bal);
        @(negedge clk);
        bus.TARJETA_RECIBIDA = 1; bus.TIPO_TRANS = tipo; bus.BALANCE_INICIAL = bal;
        @(negedge clk);
        if (!m_bloq) m_bal = bal;
    endtask

    task automatic remove_card();
        @(negedge clk);
        bus.TARJETA_RECIBIDA = 0;
        repeat (2) @(negedge clk);
    endtask

    // Back-to-back digits; returns just after the last digit's edge
    task automatic send_pin(input logic [15:0] p);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.DIGITO_STB = 1; bus.DIGITO = p[15-4*i -: 4];
        end
        @(negedge clk);
        bus.DIGITO_STB = 0;
    endtask

    task automatic send_monto(input logic [31:0] m);
        @(negedge clk);
        bus.MONTO_STB = 1; bus.MONTO = m;
        @(negedge clk);
        bus.MONTO_STB = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({bus.BALANCE_ACTUALIZADO, bus.ENTREGAR_DINERO, bus.PIN_INCORRECTO, bus.ADVERTENCIA,
             bus.BLOQUEO, bus.FONDOS_INSUFICIENTES, lim_out()} !== 7'b0 || bus.BALANCE !== 64'd0)
            $display("FAIL reset_outputs: balance=%0d flags nonzero", bus.BALANCE);
        else pass_cnt++;
        do_reset();
        @(posedge clk); #1;
        total_cnt++;
        if (bus.BALANCE !== 64'd0 || bus.BLOQUEO !== 1'b0)
            $display("FAIL reset_release: balance=%0d bloqueo=%b, want 0/0", bus.BALANCE, bus.BLOQUEO);
        else pass_cnt++;
    endtask

    task automatic test_deposito();
        logic a, e, f, l;
        do_reset();
        insert_card(0, 64'd1000);
        send_pin(PIN_OK);
        @(posedge clk); #1;
        model_pin_ok();
        total_cnt++;
        if (bus.PIN_INCORRECTO !== 1'b0) $display("FAIL dep_pin: pin_incorrecto=%b want 0", bus.PIN_INCORRECTO);
        else pass_cnt++;
        send_monto(32'd250);
        model_tx(0, 32'd250, a, e, f, l);
        total_cnt++;
        if (bus.BALANCE_ACTUALIZADO !== 1'b0)
            $display("FAIL dep_early: balance_actualizado=%b before result edge, want 0", bus.BALANCE_ACTUALIZADO);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.BALANCE !== 64'd1250 || bus.BALANCE !== m_bal)
            $display("FAIL dep_balance: got %0d want 1250", bus.BALANCE);
        else pass_cnt++;
        total_cnt++;
        if ({bus.BALANCE_ACTUALIZADO, bus.ENTREGAR_DINERO} !== {a, e})
            $display("FAIL dep_pulses: act/ent=%b%b want %b%b", bus.BALANCE_ACTUALIZADO, bus.ENTREGAR_DINERO, a, e);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.BALANCE_ACTUALIZADO !== 1'b0) $display("FAIL dep_once: act=%b want 0", bus.BALANCE_ACTUALIZADO);
        else pass_cnt++;
        remove_card();
    endtask

    task automatic test_retiro();
        logic a, e, f, l;
        do_reset();
        insert_card(1, 64'd1000);
        send_pin(PIN_OK);
        @(posedge clk); #1;
        model_pin_ok();
        send_monto(32'd400);
        model_tx(1, 32'd400, a, e, f, l);
        @(posedge clk); #1;
        total_cnt++;
        if (bus.BALANCE !== 64'd600 || bus.BALANCE !== m_bal)
            $display("FAIL wd_balance: got %0d want 600", bus.BALANCE);
        else pass_cnt++;
        total_cnt++;
        if ({bus.BALANCE_ACTUALIZADO, bus.ENTREGAR_DINERO, bus.FONDOS_INSUFICIENTES} !== {a, e, f})
            $display("FAIL wd_pulses: act/ent/fnd=%b%b%b want %b%b%b", bus.BALANCE_ACTUALIZADO,
                     bus.ENTREGAR_DINERO, bus.FONDOS_INSUFICIENTES, a, e, f);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if ({bus.BALANCE_ACTUALIZADO, bus.ENTREGAR_DINERO} !== 2'b00)
            $display("FAIL wd_once: act/ent=%b%b want 00", bus.BALANCE_ACTUALIZADO, bus.ENTREGAR_DINERO);
        else pass_cnt++;
        remove_card();
        insert_card(1, 64'd1000);
        send_pin(PIN_OK);
        @(posedge clk); #1;
        send_monto(32'd1001);
        model_tx(1, 32'd1001, a, e, f, l);
        @(posedge clk); #1;
        total_cnt++;
        if (bus.FONDOS_INSUFICIENTES !== 1'b1 || bus.BALANCE !== 64'd1000 || bus.ENTREGAR_DINERO !== 1'b0)
            $display("FAIL wd_funds: fnd=%b bal=%0d ent=%b want 1/1000/0", bus.FONDOS_INSUFICIENTES,
                     bus.BALANCE, bus.ENTREGAR_DINERO);
        else pass_cnt++;
        remove_card();
    endtask

    task automatic test_bloqueo();
        logic a, e, f, l;
        do_reset();
        insert_card(0, 64'd500);
        for (int k = 1; k <= 3; k++) begin
            send_pin(16'h9999);
            @(posedge clk); #1;
            model_pin_fail();
            total_cnt++;
            if ({bus.PIN_INCORRECTO, bus.ADVERTENCIA, bus.BLOQUEO} !== {1'b1, (k == 2) ? 1'b1 : bus.ADVERTENCIA, m_bloq}
                || (k < 3 && bus.ADVERTENCIA !== m_adv))
                $display("FAIL lock_try%0d: inc/adv/blq=%b%b%b want 1/%b/%b", k, bus.PIN_INCORRECTO,
                         bus.ADVERTENCIA, bus.BLOQUEO, m_adv, m_bloq);
            else pass_cnt++;
        end
        send_pin(PIN_OK);
        @(posedge clk); #1;
        total_cnt++;
        if (bus.PIN_INCORRECTO !== 1'b0 || bus.BLOQUEO !== 1'b1)
            $display("FAIL lock_absorb: inc=%b blq=%b want 0/1", bus.PIN_INCORRECTO, bus.BLOQUEO);
        else pass_cnt++;
        send_monto(32'd50);
        @(posedge clk); #1;
        total_cnt++;
        if (bus.BALANCE_ACTUALIZADO !== 1'b0 || bus.BALANCE !== 64'd500)
            $display("FAIL lock_monto: act=%b bal=%0d want 0/500", bus.BALANCE_ACTUALIZADO, bus.BALANCE);
        else pass_cnt++;
        remove_card();
        total_cnt++;
        if (bus.BLOQUEO !== 1'b1) $display("FAIL lock_sticky: blq=%b want 1", bus.BLOQUEO);
        else pass_cnt++;
        do_reset();
        @(posedge clk); #1;
        total_cnt++;
        if (bus.BLOQUEO !== 1'b0) $display("FAIL lock_rst: blq=%b want 0", bus.BLOQUEO);
        else pass_cnt++;
    endtask

    task automatic test_persistencia();
        do_reset();
        insert_card(0, 64'd100);
        send_pin(16'h9999);
        @(posedge clk); #1;
        model_pin_fail();
        total_cnt++;
        if (bus.PIN_INCORRECTO !== 1'b1 || bus.ADVERTENCIA !== m_adv)
            $display("FAIL keep_first: inc=%b adv=%b want 1/%b", bus.PIN_INCORRECTO, bus.ADVERTENCIA, m_adv);
        else pass_cnt++;
        remove_card();
        insert_card(0, 64'd100);
        send_pin(16'h9999);
        @(posedge clk); #1;
        model_pin_fail();
        total_cnt++;
        if (bus.PIN_INCORRECTO !== 1'b1 || bus.ADVERTENCIA !== 1'b1 || m_adv !== 1'b1)
            $display("FAIL keep_warn: inc=%b adv=%b want 1/1", bus.PIN_INCORRECTO, bus.ADVERTENCIA);
        else pass_cnt++;
        send_pin(PIN_OK);
        @(posedge clk); #1;
        model_pin_ok();
        total_cnt++;
        if (bus.ADVERTENCIA !== m_adv || bus.PIN_INCORRECTO !== 1'b0)
            $display("FAIL keep_clear: adv=%b inc=%b want 0/0", bus.ADVERTENCIA, bus.PIN_INCORRECTO);
        else pass_cnt++;
        remove_card();
    endtask

    task automatic test_abort();
        logic bad;
        do_reset();
        insert_card(0, 64'd77);
        @(negedge clk); bus.DIGITO_STB = 1; bus.DIGITO = 4'd1;
        @(negedge clk); bus.DIGITO = 4'd2;
        @(negedge clk); bus.DIGITO_STB = 0; bus.TARJETA_RECIBIDA = 0;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if ({bus.BALANCE_ACTUALIZADO, bus.ENTREGAR_DINERO, bus.PIN_INCORRECTO,
                 bus.FONDOS_INSUFICIENTES} !== 4'b0) bad = 1'b1;
        end
        total_cnt++;
        if (bad || bus.BALANCE !== 64'd77)
            $display("FAIL abort_quiet: pulse seen=%b bal=%0d want 0/77", bad, bus.BALANCE);
        else pass_cnt++;
        insert_card(0, 64'd88);
        send_pin(PIN_OK);
        @(posedge clk); #1;
        total_cnt++;
        if (bus.PIN_INCORRECTO !== 1'b0 || bus.BALANCE !== 64'd88)
            $display("FAIL abort_reentry: inc=%b bal=%0d want 0/88", bus.PIN_INCORRECTO, bus.BALANCE);
        else pass_cnt++;
        send_monto(32'd12);
        @(posedge clk); #1;
        total_cnt++;
        if (bus.BALANCE !== 64'd100 || bus.BALANCE_ACTUALIZADO !== 1'b1)
            $display("FAIL abort_tx: bal=%0d act=%b want 100/1", bus.BALANCE, bus.BALANCE_ACTUALIZADO);
        else pass_cnt++;
        remove_card();
    endtask

    task automatic test_reset_async();
        do_reset();
        insert_card(0, 64'd4242);
        send_pin(16'h9999);
        send_pin(16'h8888);
        @(posedge clk); #1;
        total_cnt++;
        if (bus.ADVERTENCIA !== 1'b1) $display("FAIL arst_pre: adv=%b want 1", bus.ADVERTENCIA);
        else pass_cnt++;
        @(negedge clk); bus.DIGITO_STB = 1; bus.DIGITO = 4'd1;
        @(negedge clk); bus.DIGITO = 4'd2;
        @(negedge clk); bus.DIGITO_STB = 0;
        #2 rst = 1'b0;
        #1;
        total_cnt++;
        if (bus.BALANCE !== 64'd0 || {bus.BALANCE_ACTUALIZADO, bus.ENTREGAR_DINERO, bus.PIN_INCORRECTO,
            bus.ADVERTENCIA, bus.BLOQUEO, bus.FONDOS_INSUFICIENTES} !== 6'b0)
            $display("FAIL arst_now: bal=%0d adv=%b want 0/0", bus.BALANCE, bus.ADVERTENCIA);
        else pass_cnt++;
        do_reset();
    endtask

    task automatic test_random();
        logic a, e, f, l;
        logic tipo;
        logic [63:0] bal;
        logic [31:0] m;
        logic [15:0] p;
        int nwrong;
        do_reset();
        for (int it = 0; it < 24; it++) begin
            tipo = 1'($urandom & 1);
            case ($urandom % 3)
                0: bal = 64'($urandom_range(0, 2000));
                1: bal = {32'hFFFF_FFFF, $urandom};
                default: bal = {$urandom, $urandom};
            endcase
            m = ($urandom % 2 == 0) ? 32'($urandom_range(0, 2000)) : $urandom;
            nwrong = $urandom_range(0, 2);
            insert_card(tipo, bal);
            for (int w = 0; w < nwrong; w++) begin
                p = 16'($urandom);
                if (p == PIN_OK) p = p ^ 16'h0001;
                send_pin(p);
                @(posedge clk); #1;
                model_pin_fail();
                total_cnt++;
                if (bus.PIN_INCORRECTO !== 1'b1 || bus.ADVERTENCIA !== m_adv)
                    $display("FAIL rnd_wrong it%0d: inc=%b adv=%b want 1/%b", it, bus.PIN_INCORRECTO,
                             bus.ADVERTENCIA, m_adv);
                else pass_cnt++;
            end
            send_pin(PIN_OK);
            @(posedge clk); #1;
            model_pin_ok();
            total_cnt++;
            if (bus.PIN_INCORRECTO !== 1'b0 || bus.ADVERTENCIA !== m_adv)
                $display("FAIL rnd_pin it%0d: inc=%b adv=%b want 0/0", it, bus.PIN_INCORRECTO, bus.ADVERTENCIA);
            else pass_cnt++;
            send_monto(m);
            model_tx(tipo, m, a, e, f, l);
            @(posedge clk); #1;
            total_cnt++;
            if (bus.BALANCE !== m_bal || {bus.BALANCE_ACTUALIZADO, bus.ENTREGAR_DINERO,
                bus.FONDOS_INSUFICIENTES, lim_out()} !== {a, e, f, l})
                $display("FAIL rnd_tx it%0d: tipo=%b m=%0d bal=%0h want %0h flags=%b%b%b%b want %b%b%b%b",
                         it, tipo, m, bus.BALANCE, m_bal, bus.BALANCE_ACTUALIZADO, bus.ENTREGAR_DINERO,
                         bus.FONDOS_INSUFICIENTES, lim_out(), a, e, f, l);
            else pass_cnt++;
            remove_card();
        end
    endtask

`ifdef LIMITE_DIARIO_EN
    task automatic test_limite();
        logic a, e, f, l;
        do_reset();
        insert_card(1, 64'd1000);
        send_pin(PIN_OK);
        @(posedge clk); #1;
        send_monto(32'd300);
        model_tx(1, 32'd300, a, e, f, l);
        @(posedge clk); #1;
        total_cnt++;
        if (bus.BALANCE !== 64'd700 || bus.ENTREGAR_DINERO !== 1'b1 || bus.LIMITE_EXCEDIDO !== 1'b0)
            $display("FAIL lim_first: bal=%0d ent=%b lim=%b want 700/1/0", bus.BALANCE,
                     bus.ENTREGAR_DINERO, bus.LIMITE_EXCEDIDO);
        else pass_cnt++;
        remove_card();
        insert_card(1, 64'd700);
        send_pin(PIN_OK);
        @(posedge clk); #1;
        send_monto(32'd300);
        model_tx(1, 32'd300, a, e, f, l);
        @(posedge clk); #1;
        total_cnt++;
        if (bus.LIMITE_EXCEDIDO !== 1'b1 || bus.BALANCE !== 64'd700 || bus.ENTREGAR_DINERO !== 1'b0
            || bus.FONDOS_INSUFICIENTES !== 1'b0 || l !== 1'b1)
            $display("FAIL lim_second: lim=%b bal=%0d ent=%b want 1/700/0", bus.LIMITE_EXCEDIDO,
                     bus.BALANCE, bus.ENTREGAR_DINERO);
        else pass_cnt++;
        remove_card();
    endtask
`endif

    initial begin
        test_reset();
        test_deposito();
        test_retiro();
        test_bloqueo();
        test_persistencia();
        test_abort();
        test_reset_async();
`ifdef LIMITE_DIARIO_EN
        test_limite();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
